// File: rtl/mem_io_responder_pkg.sv
// Shared address map and access encodings for the memory/IO responder.
// IO window decode helper used by the top level.
package mem_io_responder_pkg;

    localparam logic [31:0] IO_BASE     = 32'h0003_0000;
    localparam logic [2:0]  IO_TX_OFF   = 3'd0;
    localparam logic [2:0]  IO_STAT_OFF = 3'd4;
    localparam logic        LOAD_MEM    = 1'b0;
    localparam logic        STORE_MEM   = 1'b1;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_TX,
        SEL_STAT,
        SEL_NONE
    } sel_e;

    // Only bits [17:16] pick IO; the low three bits pick the register.
    function automatic sel_e decode(
        input logic [1:0] hi,
        input logic [2:0] off
    );
        if (hi != IO_BASE[17:16]) return SEL_RAM;
        if (off == IO_TX_OFF)     return SEL_TX;
        if (off == IO_STAT_OFF)   return SEL_STAT;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with natural-wrap pointers and an extra count bit.
// Push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdy,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_cnt == (AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign w_pop  = rdy & pop & ~empty;
    assign w_push = rdy & push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            if (w_push & ~w_pop)
                r_cnt <= r_cnt + (AW+1)'(1);
            else if (w_pop & ~w_push)
                r_cnt <= r_cnt - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

    assign dout  = r_mem[r_rd];
    assign count = r_cnt;

endmodule

// File: rtl/mem_io_responder.sv
// Byte RAM plus UART TX FIFO / RX port / status at the controller's RAM port.
// Define IO_HALT_EN to enable the sticky halt flag written at IO offset 4.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        ram_ena,
    input  logic        wr_mc2ram,
    input  logic [31:0] addr_2ram,
    input  logic [7:0]  data_2ram,
    output logic [7:0]  data_from_ram,
    output logic        uart_full_signal,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ack,
    output logic        halt
);

    localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

    logic [7:0] r_ram [2**RAM_ADDR_WIDTH];
    logic [7:0] r_rd_data;
    logic       r_rx_ack;
    logic       r_ovf;

    sel_e                      w_sel;
    logic                      w_req;
    logic                      w_wr;
    logic                      w_rd;
    logic                      w_push_req;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [CW-1:0]             w_count;
    logic [7:0]                w_io_rd;
    logic [7:0]                w_fifo_dout;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_addr;
    logic                      w_unused;

    assign w_sel      = decode(addr_2ram[17:16], addr_2ram[2:0]);
    assign w_ram_addr = addr_2ram[RAM_ADDR_WIDTH-1:0];
    assign w_unused   = ^addr_2ram;

    // Reset blocks every access so it wins over a same-cycle request.
    assign w_req = rst_n & rdy & ram_ena;
    assign w_wr  = w_req & (wr_mc2ram == STORE_MEM);
    assign w_rd  = w_req & (wr_mc2ram == LOAD_MEM);
    assign w_pop = tx_valid & tx_ready;

`ifdef IO_HALT_EN
    logic r_halt;

    assign w_push_req = w_wr & (w_sel == SEL_TX) & ~r_halt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_halt <= 1'b0;
        else if (w_wr & (w_sel == SEL_STAT))
            r_halt <= 1'b1;
    end

    assign halt = r_halt;
`else
    assign w_push_req = w_wr & (w_sel == SEL_TX);
    assign halt       = 1'b0;
`endif

    byte_fifo #(
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .push  (w_push_req),
        .din   (data_2ram),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_io_rd = 8'h00;
        unique case (w_sel)
            SEL_TX:   w_io_rd = rx_valid ? rx_data : 8'h00;
            SEL_STAT: w_io_rd = {5'b0, r_ovf, tx_valid, rx_valid};
            default:  w_io_rd = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr & (w_sel == SEL_RAM))
            r_ram[w_ram_addr] <= data_2ram;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= 8'h00;
            r_rx_ack  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_rx_ack <= w_rd & (w_sel == SEL_TX) & rx_valid;
            if (w_rd)
                r_rd_data <= (w_sel == SEL_RAM) ? r_ram[w_ram_addr]
                                                : w_io_rd;
            if (w_push_req & w_full & ~w_pop)
                r_ovf <= 1'b1;
        end
    end

    // One spare slot covers the store already in flight when this rises.
    assign uart_full_signal = (w_count >= CW'(TX_FIFO_DEPTH - 1));
    assign tx_valid         = ~w_empty;
    assign tx_data          = w_fifo_dout;
    assign data_from_ram    = r_rd_data;
    assign rx_ack           = r_rx_ack;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios then random traffic,
// all checked against a queue/array reference model.
module tb_mem_io_responder;

    localparam int DEPTH = 8;
`ifdef IO_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, rdy, ram_ena, wr_mc2ram;
    logic [31:0] addr_2ram;
    logic [7:0]  data_2ram, rx_data;
    logic        tx_ready, rx_valid;
    logic [7:0]  data_from_ram, tx_data;
    logic        uart_full_signal, tx_valid, rx_ack, halt;

    always #5 clk = ~clk;

    mem_io_responder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rdy              (rdy),
        .ram_ena          (ram_ena),
        .wr_mc2ram        (wr_mc2ram),
        .addr_2ram        (addr_2ram),
        .data_2ram        (data_2ram),
        .data_from_ram    (data_from_ram),
        .uart_full_signal (uart_full_signal),
        .tx_valid         (tx_valid),
        .tx_data          (tx_data),
        .tx_ready         (tx_ready),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ack           (rx_ack),
        .halt             (halt)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] m_mem [int];
    logic [7:0] m_q [$];
    bit         m_ovf, m_halt, m_ack;
    bit         m_known = 1'b0;
    logic [7:0] m_data;

    bit         rdy_g = 1'b1;
    bit         txr_g = 1'b0;
    bit         rxv_g = 1'b0;
    logic [7:0] rxd_g = 8'h00;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behaviour of one clock edge, from the pre-edge inputs and model state.
    task automatic model_edge();
        bit         io, pop;
        logic [2:0] off;
        int         a;
        if (!rst_n) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_halt  = 1'b0;
            m_ack   = 1'b0;
            m_data  = 8'h00;
            m_known = 1'b1;
            return;
        end
        m_ack = 1'b0;
        if (!rdy) return;
        io  = (addr_2ram[17:16] == 2'b11);
        off = addr_2ram[2:0];
        a   = int'(addr_2ram[16:0]);
        pop = tx_ready && (m_q.size() > 0);
        if (ram_ena && !wr_mc2ram) begin
            m_known = 1'b1;
            if (!io) begin
                if (m_mem.exists(a)) m_data = m_mem[a];
                else m_known = 1'b0;
            end else if (off == 3'd0) begin
                m_data = rx_valid ? rx_data : 8'h00;
                m_ack  = rx_valid;
            end else if (off == 3'd4) begin
                m_data = {5'b0, m_ovf, m_q.size() > 0, rx_valid};
            end else begin
                m_data = 8'h00;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (ram_ena && wr_mc2ram) begin
            if (!io) m_mem[a] = data_2ram;
            else if (off == 3'd0 && !m_halt) begin
                if (m_q.size() >= DEPTH) m_ovf = 1'b1;
                else m_q.push_back(data_2ram);
            end else if (off == 3'd4 && HALT_EN) begin
                m_halt = 1'b1;
            end
        end
    endtask

    task automatic check_outs(string tag);
        if (m_known) check({tag, ".data"}, data_from_ram, m_data);
        check({tag, ".ack"}, rx_ack, m_ack);
        check({tag, ".txv"}, tx_valid, m_q.size() > 0);
        check({tag, ".full"}, uart_full_signal, m_q.size() >= DEPTH - 1);
        check({tag, ".halt"}, halt, m_halt);
        if (m_q.size() > 0) check({tag, ".txd"}, tx_data, m_q[0]);
    endtask

    task automatic step(string tag, bit rn, bit ena, bit wr,
                        logic [31:0] a, logic [7:0] d);
        rst_n     = rn;
        rdy       = rdy_g;
        ram_ena   = ena;
        wr_mc2ram = wr;
        addr_2ram = a;
        data_2ram = d;
        tx_ready  = txr_g;
        rx_valid  = rxv_g;
        rx_data   = rxd_g;
        @(posedge clk);
        model_edge();
        #1;
        check_outs(tag);
    endtask

    task automatic idle(string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 32'h0, 8'h0);
    endtask

    initial begin
        logic [31:0] a;
        step("rst", 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
        step("rst", 1'b0, 1'b1, 1'b1, 32'h30000, 8'h11);
        check("rst_data", data_from_ram, 8'h00);
        check("rst_txv", tx_valid, 1'b0);
        check("rst_full", uart_full_signal, 1'b0);

        step("w11", 1'b1, 1'b1, 1'b1, 32'h11, 8'h3C);
        step("w10", 1'b1, 1'b1, 1'b1, 32'h10, 8'hA5);
        step("r10", 1'b1, 1'b1, 1'b0, 32'h10, 8'h0);
        check("rt_a5", data_from_ram, 8'hA5);
        step("r11", 1'b1, 1'b1, 1'b0, 32'h11, 8'h0);
        check("rt_3c", data_from_ram, 8'h3C);
        idle("hold");
        check("hold_3c", data_from_ram, 8'h3C);

        for (int i = 0; i < 4; i++)
            step("w1xx", 1'b1, 1'b1, 1'b1, 32'h100 + i, 8'h50 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            step("seq", 1'b1, 1'b1, 1'b0, 32'h100 + i, 8'h0);
            check("seq_byte", data_from_ram, 8'h50 + 8'(i));
        end

        txr_g = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step("fill", 1'b1, 1'b1, 1'b1, 32'h30000, 8'h60 + 8'(i));
            check("fill_full", uart_full_signal, i >= 7);
        end
        step("stat", 1'b1, 1'b1, 1'b0, 32'h30004, 8'h0);
        check("stat_ovf", data_from_ram, 8'h06);

        txr_g = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_d", tx_data, 8'h60 + 8'(i));
            idle("drain");
        end
        check("drain_empty", tx_valid, 1'b0);

        step("rst2", 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);
        txr_g = 1'b0;
        for (int i = 0; i < 8; i++)
            step("refill", 1'b1, 1'b1, 1'b1, 32'h30000, 8'h70 + 8'(i));
        txr_g = 1'b1;
        step("pushpop", 1'b1, 1'b1, 1'b1, 32'h30000, 8'h77);
        txr_g = 1'b0;
        step("pp_stat", 1'b1, 1'b1, 1'b0, 32'h30004, 8'h0);
        check("pp_stat", data_from_ram, 8'h02);
        check("pp_full", uart_full_signal, 1'b1);

        rxv_g = 1'b1;
        rxd_g = 8'h41;
        step("rx", 1'b1, 1'b1, 1'b0, 32'h30000, 8'h0);
        check("rx_data", data_from_ram, 8'h41);
        check("rx_ack_hi", rx_ack, 1'b1);
        idle("rx_after");
        check("rx_ack_lo", rx_ack, 1'b0);
        rdy_g = 1'b0;
        rxd_g = 8'h42;
        txr_g = 1'b1;
        step("rx_nordy", 1'b1, 1'b1, 1'b0, 32'h30000, 8'h0);
        check("nordy_data", data_from_ram, 8'h41);
        check("nordy_ack", rx_ack, 1'b0);
        check("nordy_txv", tx_valid, 1'b1);
        rdy_g = 1'b1;
        rxv_g = 1'b0;

        step("rst_mid", 1'b0, 1'b1, 1'b1, 32'h30000, 8'h99);
        check("mid_txv", tx_valid, 1'b0);
        check("mid_full", uart_full_signal, 1'b0);
        check("mid_data", data_from_ram, 8'h00);

        txr_g = 1'b0;
        step("halt_w", 1'b1, 1'b1, 1'b1, 32'h30004, 8'h01);
        check("halt_set", halt, HALT_EN);
        step("halt_push", 1'b1, 1'b1, 1'b1, 32'h30000, 8'h5A);
        check("halt_drop", tx_valid, !HALT_EN);
        step("rst3", 1'b0, 1'b0, 1'b0, 32'h0, 8'h0);

        for (int i = 0; i < 3000; i++) begin
            rdy_g = ($urandom_range(0, 9) != 0);
            txr_g = ($urandom_range(0, 2) == 0);
            rxv_g = $urandom_range(0, 1) == 1;
            rxd_g = 8'($urandom);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                a[17:16] = 2'b11;
                a[15:3]  = '0;
            end else begin
                a[16:0] = 17'($urandom_range(0, 63));
            end
            step("rnd", $urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 a, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
